// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: forward-select codes, mul/div FSM states,
// default unit latencies and a register-match helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int MUL_CYCLES_DEFAULT = 4;
    localparam int DIV_CYCLES_DEFAULT = 32;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A producer matches a consumer only for a real register; $0 is hardwired zero.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline (master) drives
// stage information; the controller (slave) returns stall/flush/forward controls.
interface hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, JumpD;
    logic       MdStartE, MdIsDivE, MdUseD;

    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       MdBusy, MdDone;
    logic [STALL_CNT_W-1:0] StallCnt;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, JumpD, MdStartE, MdIsDivE, MdUseD,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MdBusy, MdDone, StallCnt
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, JumpD, MdStartE, MdIsDivE, MdUseD,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MdBusy, MdDone, StallCnt
    );
endinterface

// File: rtl/hazard_ctrl_md_tracker.sv
// Tracks the multi-cycle mul/div unit: IDLE/BUSY FSM with a down-counter that
// reaches zero on the last busy cycle, where a one-cycle done pulse is raised.
module hazard_ctrl_md_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;

    assign load_val = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    assign busy     = (state_q == MD_BUSY);

    // State and counter registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a start while busy is ignored, but one landing on the final
    // busy cycle is accepted so back-to-back operations lose no cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    cnt_d   = load_val;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done    = ~rst;
                    state_d = MD_IDLE;
                    if (start) begin
                        cnt_d   = load_val;
                        state_d = MD_BUSY;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: operand forwarding, load-use / branch / mul-div
// stalls, fetch/decode flushes and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES  = MUL_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter int CNT_W       = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    hazard_ctrl_if.slave hz
);

    logic                   lw_stall, br_stall, md_stall, stall;
    logic                   stall_f, flush_d, flush_e;
    logic [1:0]             fwd_ae, fwd_be;
    logic                   fwd_ad, fwd_bd;
    logic                   md_busy, md_done;
    logic [STALL_CNT_W-1:0] stall_cnt;

    hazard_ctrl_md_tracker #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_tracker (
        .clk    (clk),
        .rst    (rst),
        .start  (hz.MdStartE),
        .is_div (hz.MdIsDivE),
        .busy   (md_busy),
        .done   (md_done)
    );

    // Stall sources: load result not ready, branch operand not ready in D,
    // or HI/LO still being produced by the mul/div unit.
    always_comb begin
        lw_stall = hz.MemtoRegE &&
                   (reg_hit(hz.WriteRegE, hz.RsD) || reg_hit(hz.WriteRegE, hz.RtD));
        br_stall = hz.BranchD &&
                   ((hz.RegWriteE &&
                     (reg_hit(hz.WriteRegE, hz.RsD) || reg_hit(hz.WriteRegE, hz.RtD))) ||
                    (hz.MemtoRegM &&
                     (reg_hit(hz.WriteRegM, hz.RsD) || reg_hit(hz.WriteRegM, hz.RtD))));
        md_stall = hz.MdUseD && (md_busy || hz.MdStartE);
        stall    = lw_stall | br_stall | md_stall;
    end

    // Control outputs; M beats W for forwarding, and a taken branch only
    // flushes once it is no longer stalled. Reset flushes and never stalls.
    always_comb begin
        stall_f = stall;
        flush_e = stall;
        flush_d = (hz.PCSrcD | hz.JumpD) & ~stall;
        fwd_ae  = FWD_RF;
        fwd_be  = FWD_RF;
        if (hz.RegWriteM && reg_hit(hz.WriteRegM, hz.RsE))      fwd_ae = FWD_M;
        else if (hz.RegWriteW && reg_hit(hz.WriteRegW, hz.RsE)) fwd_ae = FWD_W;
        if (hz.RegWriteM && reg_hit(hz.WriteRegM, hz.RtE))      fwd_be = FWD_M;
        else if (hz.RegWriteW && reg_hit(hz.WriteRegW, hz.RtE)) fwd_be = FWD_W;
        fwd_ad  = hz.RegWriteM && reg_hit(hz.WriteRegM, hz.RsD);
        fwd_bd  = hz.RegWriteM && reg_hit(hz.WriteRegM, hz.RtD);
        if (rst) begin
            stall_f = 1'b0;
            flush_e = 1'b1;
            flush_d = 1'b1;
            fwd_ae  = FWD_RF;
            fwd_be  = FWD_RF;
            fwd_ad  = 1'b0;
            fwd_bd  = 1'b0;
        end
    end

    // Saturating count of fetch-stall cycles for performance debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_f;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.ForwardAE = fwd_ae;
    assign hz.ForwardBE = fwd_be;
    assign hz.ForwardAD = fwd_ad;
    assign hz.ForwardBD = fwd_bd;
    assign hz.MdBusy    = md_busy;
    assign hz.MdDone    = md_done;
    assign hz.StallCnt  = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if #(.STALL_CNT_W(16)) hz();

    hazard_ctrl #(
        .MUL_CYCLES  (4),
        .DIV_CYCLES  (32),
        .CNT_W       (6),
        .STALL_CNT_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: cycles of mul/div work still outstanding, and stall count.
    int md_rem    = 0;
    int cnt_model = 0;

    logic       exp_stall, exp_flushd, exp_flushe, exp_busy, exp_done;
    logic [1:0] exp_fae, exp_fbe;
    logic       exp_fad, exp_fbd;

    function automatic bit hits(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic void model_eval();
        bit lw, br, md;
        lw = hz.MemtoRegE && (hits(hz.WriteRegE, hz.RsD) || hits(hz.WriteRegE, hz.RtD));
        br = hz.BranchD &&
             ((hz.RegWriteE && (hits(hz.WriteRegE, hz.RsD) || hits(hz.WriteRegE, hz.RtD))) ||
              (hz.MemtoRegM && (hits(hz.WriteRegM, hz.RsD) || hits(hz.WriteRegM, hz.RtD))));
        md = hz.MdUseD && (md_rem > 0 || hz.MdStartE);
        exp_busy = (md_rem > 0);
        exp_done = (md_rem == 1) && !rst;
        if (rst) begin
            exp_stall = 0; exp_flushd = 1; exp_flushe = 1;
            exp_fae = 0; exp_fbe = 0; exp_fad = 0; exp_fbd = 0;
        end else begin
            exp_stall  = lw | br | md;
            exp_flushe = exp_stall;
            exp_flushd = (hz.PCSrcD | hz.JumpD) & !exp_stall;
            exp_fae = (hz.RegWriteM && hits(hz.WriteRegM, hz.RsE)) ? 2'd2 :
                      (hz.RegWriteW && hits(hz.WriteRegW, hz.RsE)) ? 2'd1 : 2'd0;
            exp_fbe = (hz.RegWriteM && hits(hz.WriteRegM, hz.RtE)) ? 2'd2 :
                      (hz.RegWriteW && hits(hz.WriteRegW, hz.RtE)) ? 2'd1 : 2'd0;
            exp_fad = hz.RegWriteM && hits(hz.WriteRegM, hz.RsD);
            exp_fbd = hz.RegWriteM && hits(hz.WriteRegM, hz.RtD);
        end
    endfunction

    function automatic void model_tick();
        if (rst) begin
            md_rem    = 0;
            cnt_model = 0;
        end else begin
            if (exp_stall && cnt_model < 65535) cnt_model++;
            if (hz.MdStartE && md_rem <= 1) md_rem = hz.MdIsDivE ? 32 : 4;
            else if (md_rem > 0)            md_rem--;
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_eval();
        model_tick();
        #1;
    endtask

    task automatic clear_inputs();
        hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemtoRegE = 0; hz.MemtoRegM = 0;
        hz.BranchD = 0; hz.PCSrcD = 0; hz.JumpD = 0;
        hz.MdStartE = 0; hz.MdIsDivE = 0; hz.MdUseD = 0;
    endtask

    task automatic rand_inputs();
        hz.RsD = 5'($urandom_range(0, 3)); hz.RtD = 5'($urandom_range(0, 3));
        hz.RsE = 5'($urandom_range(0, 3)); hz.RtE = 5'($urandom_range(0, 3));
        hz.WriteRegE = 5'($urandom_range(0, 3));
        hz.WriteRegM = 5'($urandom_range(0, 3));
        hz.WriteRegW = 5'($urandom_range(0, 3));
        hz.RegWriteE = 1'($urandom); hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
        hz.MemtoRegE = 1'($urandom); hz.MemtoRegM = 1'($urandom);
        hz.BranchD = 1'($urandom); hz.PCSrcD = 1'($urandom); hz.JumpD = 1'($urandom);
        hz.MdStartE = ($urandom_range(0, 7) == 0);
        hz.MdIsDivE = 1'($urandom);
        hz.MdUseD   = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        advance();
        advance();
        rst = 0;
    endtask

    // Vector order: StallF StallD FlushD FlushE ForwardAE ForwardBE ForwardAD ForwardBD MdBusy MdDone
    function automatic logic [11:0] dut_vec();
        return {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.ForwardAE, hz.ForwardBE,
                hz.ForwardAD, hz.ForwardBD, hz.MdBusy, hz.MdDone};
    endfunction

    task automatic test_reset();
        rst = 1;
        rand_inputs();
        advance();
        rand_inputs();
        settle();
        n_tests++;
        if (dut_vec() !== 12'b0011_0000_0000) begin
            n_fail++;
            $display("[TB] FAIL reset_controls: got %b want %b", dut_vec(), 12'b0011_0000_0000);
        end
        n_tests++;
        if (hz.StallCnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_stallcnt: got %0d want 0", hz.StallCnt);
        end
        advance();
        rst = 0;
        clear_inputs();
        advance();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 8; hz.RsD = 8; hz.RtD = 9;
        settle();
        n_tests++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL loaduse_stall: got %b want 111", {hz.StallF, hz.StallD, hz.FlushE});
        end
        advance();
        hz.MemtoRegE = 0; hz.RegWriteE = 0; hz.WriteRegE = 0;
        hz.MemtoRegM = 1; hz.RegWriteM = 1; hz.WriteRegM = 8;
        settle();
        n_tests++;
        if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL loaduse_release: got %b want 000", {hz.StallF, hz.StallD, hz.FlushE});
        end
        advance();
        clear_inputs();
        hz.RegWriteW = 1; hz.WriteRegW = 8; hz.RsE = 8; hz.RtE = 9;
        settle();
        n_tests++;
        if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL loaduse_fwd_w: got %b want 0100", {hz.ForwardAE, hz.ForwardBE});
        end
        advance();
    endtask

    task automatic test_forward_priority();
        clear_inputs();
        hz.RegWriteM = 1; hz.RegWriteW = 1;
        hz.WriteRegM = 5; hz.WriteRegW = 5; hz.RsE = 5; hz.RtE = 5; hz.RsD = 5;
        settle();
        n_tests++;
        if ({hz.ForwardAE, hz.ForwardBE, hz.ForwardAD} !== 5'b10101) begin
            n_fail++;
            $display("[TB] FAIL fwd_m_priority: got %b want 10101", {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD});
        end
        advance();
        hz.WriteRegM = 7;
        settle();
        n_tests++;
        if ({hz.ForwardAE, hz.ForwardAD} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL fwd_w_only: got %b want 010", {hz.ForwardAE, hz.ForwardAD});
        end
        advance();
        hz.WriteRegM = 0; hz.WriteRegW = 0; hz.RsE = 0; hz.RtE = 0; hz.RsD = 0; hz.RtD = 0;
        settle();
        n_tests++;
        if ({hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD} !== 6'b000000) begin
            n_fail++;
            $display("[TB] FAIL fwd_reg0: got %b want 000000",
                     {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD});
        end
        advance();
    endtask

    task automatic test_branch();
        clear_inputs();
        hz.BranchD = 1; hz.PCSrcD = 1; hz.RsD = 3; hz.RtD = 4;
        hz.RegWriteE = 1; hz.WriteRegE = 3;
        settle();
        n_tests++;
        if ({hz.StallF, hz.FlushE, hz.FlushD} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL branch_stall: got %b want 110", {hz.StallF, hz.FlushE, hz.FlushD});
        end
        advance();
        hz.RegWriteE = 0; hz.WriteRegE = 0; hz.RegWriteM = 1; hz.WriteRegM = 3;
        settle();
        n_tests++;
        if ({hz.StallF, hz.ForwardAD, hz.ForwardBD, hz.FlushD} !== 4'b0101) begin
            n_fail++;
            $display("[TB] FAIL branch_resolve: got %b want 0101",
                     {hz.StallF, hz.ForwardAD, hz.ForwardBD, hz.FlushD});
        end
        advance();
        clear_inputs();
        settle();
        n_tests++;
        if (hz.FlushD !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL branch_flush_once: got %b want 0", hz.FlushD);
        end
        advance();
    endtask

    task automatic test_div();
        int stalls = 0, busy_cycles = 0, done_cnt = 0, done_at = -1;
        do_reset();
        hz.MdStartE = 1; hz.MdIsDivE = 1; hz.MdUseD = 1;
        for (int c = 0; c < 45; c++) begin
            settle();
            if (hz.StallF === 1'b1) stalls++;
            if (hz.MdBusy === 1'b1) busy_cycles++;
            if (hz.MdDone === 1'b1) begin
                done_cnt++;
                done_at = busy_cycles;
            end
            advance();
            hz.MdStartE = 0; hz.MdIsDivE = 0;
        end
        settle();
        n_tests++;
        if (stalls != 33) begin
            n_fail++;
            $display("[TB] FAIL div_stall_cycles: got %0d want 33", stalls);
        end
        n_tests++;
        if (busy_cycles != 32) begin
            n_fail++;
            $display("[TB] FAIL div_busy_cycles: got %0d want 32", busy_cycles);
        end
        n_tests++;
        if (done_cnt != 1 || done_at != 32) begin
            n_fail++;
            $display("[TB] FAIL div_done: got %0d pulses at busy cycle %0d want 1 at 32", done_cnt, done_at);
        end
        n_tests++;
        if (hz.StallCnt !== 16'd33) begin
            n_fail++;
            $display("[TB] FAIL div_stallcnt: got %0d want 33", hz.StallCnt);
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_md_reset();
        bit seen = 0;
        do_reset();
        hz.MdStartE = 1; hz.MdIsDivE = 0;
        settle();
        advance();
        hz.MdStartE = 0;
        settle();
        n_tests++;
        if (hz.MdBusy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mdrst_busy1: got %b want 1", hz.MdBusy);
        end
        advance();
        rst = 1;
        settle();
        n_tests++;
        if ({hz.StallF, hz.FlushD, hz.FlushE, hz.MdDone} !== 4'b0110) begin
            n_fail++;
            $display("[TB] FAIL mdrst_during: got %b want 0110", {hz.StallF, hz.FlushD, hz.FlushE, hz.MdDone});
        end
        advance();
        rst = 0;
        settle();
        n_tests++;
        if ({hz.MdBusy, hz.StallCnt} !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL mdrst_after: busy %b stallcnt %0d want 0 0", hz.MdBusy, hz.StallCnt);
        end
        for (int c = 0; c < 6; c++) begin
            settle();
            if (hz.MdDone === 1'b1 || hz.MdBusy === 1'b1) seen = 1;
            advance();
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("[TB] FAIL mdrst_no_done: got activity 1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            hz.MdStartE = (c == 0 || c == 2 || c == 4);
            hz.MdIsDivE = 0;
            settle();
            want = {(c >= 1 && c <= 8), (c == 4 || c == 8)};
            n_tests++;
            if ({hz.MdBusy, hz.MdDone} !== want) begin
                n_fail++;
                $display("[TB] FAIL b2b_cycle%0d: got %b want %b", c, {hz.MdBusy, hz.MdDone}, want);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [11:0] want;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            rand_inputs();
            settle();
            want = {exp_stall, exp_stall, exp_flushd, exp_flushe, exp_fae, exp_fbe,
                    exp_fad, exp_fbd, exp_busy, exp_done};
            n_tests++;
            if (dut_vec() !== want) begin
                n_fail++;
                $display("[TB] FAIL rand_ctrl_%0d: got %b want %b", c, dut_vec(), want);
            end
            n_tests++;
            if (hz.StallCnt !== 16'(cnt_model)) begin
                n_fail++;
                $display("[TB] FAIL rand_cnt_%0d: got %0d want %0d", c, hz.StallCnt, cnt_model);
            end
            advance();
        end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        hz.MemtoRegE = 1; hz.WriteRegE = 8; hz.RsD = 8;
        for (int i = 0; i < 65534; i++) advance();
        settle();
        n_tests++;
        if (hz.StallCnt !== 16'hFFFE) begin
            n_fail++;
            $display("[TB] FAIL sat_pre: got %h want fffe", hz.StallCnt);
        end
        advance();
        settle();
        n_tests++;
        if (hz.StallCnt !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL sat_reach: got %h want ffff", hz.StallCnt);
        end
        for (int i = 0; i < 6; i++) advance();
        settle();
        n_tests++;
        if (hz.StallCnt !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: got %h want ffff", hz.StallCnt);
        end
        advance();
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        advance();
        advance();
        test_reset();
        test_load_use();
        test_forward_priority();
        test_branch();
        test_div();
        test_md_reset();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the stall and flush controls of the F/D/E pipeline registers and the E/D-stage forwarding selects. It also owns a small FSM that tracks the multi-cycle mul/div unit and holds dependent instructions in D until HI/LO is valid. A saturating stall-cycle counter is included for performance debug.

Parameters:
MUL_CYCLES, 4, cycles the mul unit is busy after issue (≥1)
DIV_CYCLES, 32, cycles the div unit is busy after issue (≥1)
CNT_W, 6, width of the mul/div down-counter; must hold max(MUL_CYCLES,DIV_CYCLES)-1
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
RsD, RtD  in  5  source registers of the instruction in D
RsE, RtE  in  5  source registers of the instruction in E
WriteRegE, WriteRegM, WriteRegW  in  5  destination registers in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables in E/M/W
MemtoRegE, MemtoRegM  in  1  the instruction in that stage is a load
BranchD  in  1  the instruction in D is a conditional branch
PCSrcD  in  1  branch in D resolved taken
JumpD  in  1  jump in D
MdStartE  in  1  mul/div issued from E this cycle
MdIsDivE  in  1  with MdStartE: 1 = div, 0 = mul
MdUseD  in  1  the instruction in D reads HI/LO or is a mul/div
StallF  out  1  hold PC (1 = hold)
StallD  out  1  IF/ID enable; 1 = hold (IF/ID updates only when 0)
FlushD  out  1  IF/ID clear; effective only when StallD=0
FlushE  out  1  ID/EX clear
ForwardAE, ForwardBE  out  2  E operand select: 00 = RF, 01 = W result, 10 = M ALU result
ForwardAD, ForwardBD  out  1  D branch-compare operand from M ALU result
MdBusy  out  1  mul/div unit busy
MdDone  out  1  one-cycle pulse on the last busy cycle
StallCnt  out  STALL_CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Clock: clk, single domain. Reset: rst, synchronous, active-high.
- Reset: state IDLE, counter 0, MdBusy=0, MdDone=0, StallCnt=0.
- While rst=1: StallF=StallD=0, FlushD=FlushE=1, forwards 0.
- Hazard outputs are combinational from the inputs and the registered state, so they take effect in the same cycle.
- Register $0 never matches any hazard or forward condition.
- ForwardAE:
  - 10 if RegWriteM && WriteRegM==RsE.
  - Otherwise 01 if RegWriteW && WriteRegW==RsE.
  - Otherwise 00. M has priority over W.
  - ForwardBE is the same rule with RtE.
- ForwardAD = RegWriteM && WriteRegM==RsD. ForwardBD is the same with RtD.
- lwStall = MemtoRegE && WriteRegE∈{RsD,RtD}.
- brStall = BranchD && ((RegWriteE && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM∈{RsD,RtD})).
- mdStall = MdUseD && (state==BUSY || MdStartE).
- stall = lwStall | brStall | mdStall.
- Stall outputs: StallF = StallD = stall, FlushE = stall.
- FlushD = (PCSrcD | JumpD) & ~stall. A branch decision is not final while stalled.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE & MdStartE: counter ← (MdIsDivE ? DIV_CYCLES : MUL_CYCLES) - 1, go to BUSY.
  - BUSY & counter≠0: counter decrements.
  - BUSY & counter==0: go to IDLE, MdDone=1 in that cycle.
- MdBusy = (state==BUSY).
- MdStartE while BUSY is illegal; it is ignored and the counter is unchanged.
- A new MdStartE in the same cycle BUSY ends, or in any later IDLE cycle, is accepted; back-to-back issue is supported.
- StallCnt increments each cycle StallF=1 and saturates at all-ones.
- rst mid-operation: the FSM drops to IDLE at the next edge, and MdDone is not asserted for the aborted op.

Decomposition:
- Shared pipeline package holds:
  - forward-select encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - FSM state encoding MD_IDLE/MD_BUSY;
  - default latencies MUL_CYCLES and DIV_CYCLES.
- One natural sub-module: md_tracker, covering the FSM, counter, MdBusy and MdDone.
- Forwarding and stall logic stay in the top level.

Test Plan:
- Load-use: lw $8 in E (MemtoRegE=1, WriteRegE=8), add in D with RsD=8 → exactly 1 cycle with StallF=StallD=FlushE=1. Next cycle ForwardAE=01 once the lw reaches W.
- Forward priority: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=RsE=5 → ForwardAE=10. With WriteRegM=WriteRegW=0 and RsE=0 → ForwardAE=00.
- Branch in D, RsD=3, RegWriteE=1, WriteRegE=3 → stall 1 cycle, then ForwardAD=1. PCSrcD=1 during the stall → FlushD=0; after the stall → FlushD=1 for 1 cycle.
- div issued (MdStartE=1, MdIsDivE=1) with mfhi in D → mdStall active in the issue cycle plus 32 BUSY cycles (33 stall cycles). MdDone pulses on the 32nd BUSY cycle. StallCnt=33 afterwards.
- mul issued, then rst asserted on BUSY cycle 2 → MdBusy=0 next cycle, no MdDone, StallCnt=0, FlushD=FlushE=1 while rst=1.
- Drive StallF high for 2^16+5 cycles → StallCnt holds 16'hFFFF.
